// File: rtl/cmdin_queue_scheduler.sv
// Round-robin drain of the per-accelerator CmdIn subqueues in BRAM onto the cmdin_out AXI-Stream.
// Optional build macro CMDIN_SCHED_STATS_EN adds the cmds_dispatched counter port.
module cmdin_queue_scheduler #(
  parameter int MAX_ACCS           = 16,
  parameter int CMDIN_SUBQUEUE_LEN = 64
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic [MAX_ACCS-1:0]         acc_ready,
  output logic                        cmdin_out_tvalid,
  input  logic                        cmdin_out_tready,
  output logic [$clog2(MAX_ACCS)-1:0] cmdin_out_tdest,
  output logic [63:0]                 cmdin_out_tdata,
  output logic                        cmdin_out_tlast,
  output logic                        cmdin_queue_clk,
  output logic                        cmdin_queue_rst,
  output logic                        cmdin_queue_en,
  output logic [7:0]                  cmdin_queue_we,
  output logic [31:0]                 cmdin_queue_addr,
  output logic [63:0]                 cmdin_queue_din,
  input  logic [63:0]                 cmdin_queue_dout
`ifdef CMDIN_SCHED_STATS_EN
  ,
  output logic [31:0]                 cmds_dispatched
`endif
);

  localparam int AW = $clog2(MAX_ACCS);
  localparam int SW = $clog2(CMDIN_SUBQUEUE_LEN);
  localparam logic [SW-1:0] SLOT_ONE = SW'(1);
  localparam logic [AW-1:0] ACC_ONE  = AW'(1);

  typedef enum logic [2:0] {RD_HDR, CHK, SEND, LATCH, CLR} state_t;

  state_t        state;
  logic [SW-1:0] head [MAX_ACCS];
  logic [AW-1:0] cur;
  logic [7:0]    rem;
  logic [SW-1:0] rd_ptr;
  logic [SW-1:0] slot;
  logic [7:0]    hdr_n;
  logic          rd_payload;

  assign hdr_n      = cmdin_queue_dout[39:32];
  assign rd_payload = (state == SEND) && cmdin_out_tready && (rem != 8'd0);

  assign cmdin_queue_clk = aclk;
  assign cmdin_queue_rst = rst;
  assign cmdin_queue_din = 64'd0;

  // The payload read has to go out in the same cycle as the handshake, so the
  // BRAM port is decoded from state; rst gates it so the port idles in reset.
  always_comb begin
    cmdin_queue_en = 1'b0;
    cmdin_queue_we = 8'h00;
    slot           = head[cur];
    if (!rst) begin
      case (state)
        RD_HDR: cmdin_queue_en = 1'b1;
        SEND: begin
          if (rd_payload) begin
            cmdin_queue_en = 1'b1;
            slot           = rd_ptr;
          end
        end
        CLR: begin
          cmdin_queue_en = 1'b1;
          cmdin_queue_we = 8'hFF;
        end
        default: ;
      endcase
    end
  end

  assign cmdin_queue_addr = cmdin_queue_en ? 32'({cur, slot, 3'b000}) : 32'd0;

  // rd_ptr walks the payload slots; once the command is done it is the new head.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state            <= RD_HDR;
      cur              <= '0;
      rem              <= '0;
      rd_ptr           <= '0;
      for (int a = 0; a < MAX_ACCS; a++) head[a] <= '0;
      cmdin_out_tvalid <= 1'b0;
      cmdin_out_tdest  <= '0;
      cmdin_out_tdata  <= '0;
      cmdin_out_tlast  <= 1'b0;
    end else begin
      case (state)
        RD_HDR: state <= CHK;
        CHK: begin
          if (cmdin_queue_dout[63] && acc_ready[cur]) begin
            cmdin_out_tdata  <= cmdin_queue_dout;
            cmdin_out_tdest  <= cur;
            cmdin_out_tlast  <= (hdr_n == 8'd0);
            cmdin_out_tvalid <= 1'b1;
            rem              <= hdr_n;
            rd_ptr           <= head[cur] + SLOT_ONE;
            state            <= SEND;
          end else begin
            cur   <= cur + ACC_ONE;
            state <= RD_HDR;
          end
        end
        SEND: begin
          if (cmdin_out_tready) begin
            cmdin_out_tvalid <= 1'b0;
            if (rem == 8'd0) begin
              cmdin_out_tlast <= 1'b0;
              state           <= CLR;
            end else begin
              rem    <= rem - 8'd1;
              rd_ptr <= rd_ptr + SLOT_ONE;
              state  <= LATCH;
            end
          end
        end
        LATCH: begin
          cmdin_out_tdata  <= cmdin_queue_dout;
          cmdin_out_tlast  <= (rem == 8'd0);
          cmdin_out_tvalid <= 1'b1;
          state            <= SEND;
        end
        CLR: begin
          head[cur] <= rd_ptr;
          cur       <= cur + ACC_ONE;
          state     <= RD_HDR;
        end
        default: state <= RD_HDR;
      endcase
    end
  end

`ifdef CMDIN_SCHED_STATS_EN
  always_ff @(posedge aclk) begin
    if (rst) begin
      cmds_dispatched <= 32'd0;
    end else if (state == CLR) begin
      cmds_dispatched <= cmds_dispatched + 32'd1;
    end
  end
`endif

endmodule
